fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the RISC-ARM pipeline. It sits directly upstream of the decode/control-unit mux and IF/ID boundary. It owns the PC register and the PC+4 increment, and drives a request/ready instruction-memory port. It delivers {instruction, PC+4, valid} into the IF/ID pipeline register, honouring hazard-unit stalls and taken-branch flushes. A one-entry skid buffer ensures no fetched word is lost during a stall.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000000, instruction word driven into IF/ID on bubble or flush

Ports:
CLK  input  1  pipeline clock; all state updates on posedge
CLR  input  1  asynchronous reset, active-low (CLR=0 resets immediately, independent of CLK)
stall_i  input  1  hazard unit: hold IF/ID contents this cycle
branch_taken_i  input  1  redirect PC and flush younger fetches
branch_target_i  input  32  redirect address, sampled when branch_taken_i=1
imem_req_o  output  1  instruction-memory request
imem_addr_o  output  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0
imem_rdata_i  input  32  instruction word, valid in the cycle imem_ready_i=1
imem_ready_i  input  1  one-cycle completion pulse; ignored when imem_req_o=0
ifid_instr_o  output  32  IF/ID instruction register
ifid_pc4_o  output  32  IF/ID PC+4 register
ifid_valid_o  output  1  IF/ID contents are a real instruction
fetch_busy_o  output  1  request outstanding and not completed this cycle

Behaviour:
- Reset (CLR=0, asynchronous) takes effect immediately:
  - PC=RESET_PC, state=BOOT, skid empty.
  - ifid_instr_o=NOP_INSTR, ifid_pc4_o=0, ifid_valid_o=0.
  - imem_req_o=0, imem_addr_o=RESET_PC, fetch_busy_o=0.
  - A reset in any state, including DRAIN, abandons the outstanding request. The memory is required to tolerate request withdrawal on reset.
- States: BOOT, REQ, DRAIN.
- BOOT: imem_req_o=0 for exactly one cycle after CLR releases, then go to REQ.
- REQ:
  - imem_req_o = !skid_full; imem_addr_o = PC.
  - accept = imem_req_o & imem_ready_i.
- DRAIN:
  - imem_req_o=1; imem_addr_o = drain_addr, the address latched when the redirect hit an outstanding request.
  - On imem_ready_i: discard rdata and go to REQ.
- Posedge priority in REQ (highest first):
  1. branch_taken_i:
     - PC<=branch_target_i; ifid_valid_o<=0; ifid_instr_o<=NOP_INSTR; skid cleared.
     - If imem_req_o & !imem_ready_i: drain_addr<=PC, go to DRAIN. Otherwise stay in REQ; any same-cycle accepted word is discarded.
  2. stall_i: IF/ID holds all three registers.
     - If accept: skid<={rdata, PC+4}, skid_full<=1, PC<=PC+4.
  3. Otherwise:
     - If skid_full: IF/ID<={skid, valid=1}, skid_full<=0. No accept is possible because req=0.
     - Else if accept: IF/ID<={imem_rdata_i, PC+4, 1}, PC<=PC+4.
     - Else bubble: ifid_valid_o<=0, ifid_instr_o<=NOP_INSTR, ifid_pc4_o holds.
- DRAIN at posedge:
  - branch_taken_i: PC<=new target (last redirect wins); IF/ID flushed as above.
  - Stall has no effect on DRAIN progress.
- Latency: with no stalls and ready tied high, one instruction per cycle. An instruction returned in cycle N appears on ifid_* after posedge N.
- Arithmetic: PC+4 is unsigned 32-bit, wrapping 32'hFFFFFFFC -> 32'h00000000. No alignment check; target bits [1:0] are passed through unchanged.
- fetch_busy_o = (state==DRAIN) | (state==REQ & imem_req_o & !imem_ready_i).
- Simultaneous stall_i and branch_taken_i: the branch wins, and IF/ID is flushed despite the stall.
- Skid full with stall_i still high: req stays 0 and PC holds until the stall drops.

Test Plan:
- Reset, then ready tied 1 and rdata=addr+1000 -> BOOT cycle with req=0; then ifid_pc4_o = 4, 8, 12, ... with ifid_instr_o = 1000, 1004, 1008, ... on consecutive cycles; valid=1.
- ready low for 3 cycles at PC=0x10 -> imem_addr_o stays 0x10, fetch_busy_o=1, three bubbles (valid=0, instr=NOP_INSTR); the word is accepted on the 4th cycle.
- stall_i=1 for 2 cycles while ready=1 at PC=0x20 -> IF/ID holds; word at 0x20 goes to skid; req=0 in the second cycle; after the stall, IF/ID gets 0x20's word with pc4=0x24, then 0x24's word.
- branch_taken_i with target 0x100 while a request to 0x30 is outstanding -> DRAIN with addr held at 0x30; the 0x30 data is discarded on ready; next request is to 0x100; IF/ID is flushed to NOP_INSTR.
- branch_taken_i and stall_i together with the skid full -> skid cleared, IF/ID flushed, PC=target.
- PC=0xFFFFFFFC fetch -> ifid_pc4_o=0x00000000 and the next address is 0. CLR pulsed low mid-DRAIN -> outputs return to reset values immediately, without waiting for CLK.

Source files
------------

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_stage : PC register, instruction-memory request port, skid buffer
//               and IF/ID pipeline register of the RISC-ARM pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;
  logic        r_skid_full;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic        w_req;
  logic        w_accept;
  logic [31:0] w_pc4;

  assign w_req    = ((r_state == ST_REQ) && !r_skid_full) || (r_state == ST_DRAIN);
  assign w_accept = (r_state == ST_REQ) && w_req && imem_ready_i;
  assign w_pc4    = r_pc + 32'd4;

  assign imem_req_o   = w_req;
  assign imem_addr_o  = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign fetch_busy_o = (r_state == ST_DRAIN) ||
                        ((r_state == ST_REQ) && w_req && !imem_ready_i);

  assign ifid_instr_o = r_ifid_instr;
  assign ifid_pc4_o   = r_ifid_pc4;
  assign ifid_valid_o = r_ifid_valid;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= 32'h0;
      r_skid_full  <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'h0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_REQ;

        ST_REQ: begin
          if (branch_taken_i) begin
            // An un-completed request must still be drained before redirecting.
            r_pc         <= branch_target_i;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_skid_full  <= 1'b0;
            if (w_req && !imem_ready_i) begin
              r_drain_addr <= r_pc;
              r_state      <= ST_DRAIN;
            end
          end else if (stall_i) begin
            if (w_accept) begin
              r_skid_instr <= imem_rdata_i;
              r_skid_pc4   <= w_pc4;
              r_skid_full  <= 1'b1;
              r_pc         <= w_pc4;
            end
          end else if (r_skid_full) begin
            r_ifid_instr <= r_skid_instr;
            r_ifid_pc4   <= r_skid_pc4;
            r_ifid_valid <= 1'b1;
            r_skid_full  <= 1'b0;
          end else if (w_accept) begin
            r_ifid_instr <= imem_rdata_i;
            r_ifid_pc4   <= w_pc4;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc4;
          end else begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
          end
        end

        ST_DRAIN: begin
          if (branch_taken_i) begin
            r_pc         <= branch_target_i;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
          end
          if (imem_ready_i) begin
            r_state <= ST_REQ;
          end
        end

        default: r_state <= ST_BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed and randomized checks of fetch_stage against a
//                  transaction-level reference model.
// Revision       : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        stall_i, branch_taken_i, imem_ready_i;
  logic [31:0] branch_target_i, imem_rdata_i;
  logic        imem_req_o, ifid_valid_o, fetch_busy_o;
  logic [31:0] imem_addr_o, ifid_instr_o, ifid_pc4_o;

  always #5 CLK = ~CLK;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .CLR(CLR),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_ready_i(imem_ready_i),
    .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o), .ifid_valid_o(ifid_valid_o),
    .fetch_busy_o(fetch_busy_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: fetched-but-undelivered words live in a queue.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t        skid_q[$];
  logic [31:0] m_pc, m_drain_addr, m_instr, m_pc4;
  logic        m_valid, m_boot, m_drain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_req();
    if (m_boot) return 1'b0;
    if (m_drain) return 1'b1;
    return (skid_q.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_drain_addr = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
    m_valid = 1'b0; m_boot = 1'b1; m_drain = 1'b0;
    skid_q.delete();
  endtask

  task automatic m_flush();
    m_valid = 1'b0;
    m_instr = NOP;
  endtask

  task automatic m_step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] rd);
    logic got;
    ent_t e;
    if (m_boot) begin m_boot = 1'b0; return; end
    got = m_req() && rdy;
    if (m_drain) begin
      if (br) begin m_pc = tgt; m_flush(); end
      if (rdy) m_drain = 1'b0;
      return;
    end
    if (br) begin
      if (m_req() && !rdy) begin m_drain = 1'b1; m_drain_addr = m_pc; end
      m_pc = tgt;
      m_flush();
      skid_q.delete();
      return;
    end
    if (st) begin
      if (got) begin
        e.instr = rd; e.pc4 = m_pc + 32'd4;
        skid_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      return;
    end
    if (skid_q.size() > 0) begin
      e = skid_q.pop_front();
      m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
    end else if (got) begin
      m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_flush();
    end
  endtask

  task automatic check_model();
    chk("ifid_instr", ifid_instr_o, m_instr);
    chk("ifid_pc4", ifid_pc4_o, m_pc4);
    chk("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
    chk("imem_req", 32'(imem_req_o), 32'(m_req()));
    chk("imem_addr", imem_addr_o, m_addr());
  endtask

  logic last_busy;

  // One clock: check state, apply inputs in the low phase, advance model.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
    logic [31:0] rd;
    logic        mb;
    check_model();
    rd = m_addr() + 32'd1000;
    stall_i = st; branch_taken_i = br; branch_target_i = tgt;
    imem_ready_i = rdy; imem_rdata_i = rd;
    mb = m_drain || (!m_boot && m_req() && !rdy);
    #1;
    last_busy = fetch_busy_o;
    chk("busy", 32'(fetch_busy_o), 32'(mb));
    m_step(st, br, tgt, rdy, rd);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 32'h0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
    chk({tag, "_busy"}, 32'(fetch_busy_o), 32'h0);
    chk({tag, "_instr"}, ifid_instr_o, NOP);
    chk({tag, "_pc4"}, ifid_pc4_o, 32'h0);
    chk({tag, "_valid"}, 32'(ifid_valid_o), 32'h0);
  endtask

  initial begin
    CLR = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    imem_ready_i = 1'b0; imem_rdata_i = 32'h0;
    m_reset();
    #2;
    chk_reset_outputs("reset");
    @(negedge CLK);
    CLR = 1'b1;

    // Boot cycle, then one instruction per cycle.
    chk("boot_req", 32'(imem_req_o), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("seq_pc4", ifid_pc4_o, 32'((i + 1) * 4));
      chk("seq_instr", ifid_instr_o, 32'(1000 + 4 * i));
      chk("seq_valid", 32'(ifid_valid_o), 32'h1);
    end

    // Memory wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr_o, 32'h10);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      chk("wait_busy", 32'(last_busy), 32'h1);
      chk("wait_valid", 32'(ifid_valid_o), 32'h0);
      chk("wait_instr", ifid_instr_o, NOP);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wait_done_pc4", ifid_pc4_o, 32'h14);
    chk("wait_done_instr", ifid_instr_o, 32'h10 + 32'd1000);

    // Two-cycle stall at 0x20 fills the skid.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stall_addr", imem_addr_o, 32'h20);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_hold_pc4", ifid_pc4_o, 32'h20);
    chk("stall_req", 32'(imem_req_o), 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_hold2_pc4", ifid_pc4_o, 32'h20);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("skid_pc4", ifid_pc4_o, 32'h24);
    chk("skid_instr", ifid_instr_o, 32'h20 + 32'd1000);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("after_skid_pc4", ifid_pc4_o, 32'h28);
    chk("after_skid_instr", ifid_instr_o, 32'h24 + 32'd1000);

    // Redirect while the request to 0x30 is outstanding.
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_br_addr", imem_addr_o, 32'h30);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    chk("drain_addr", imem_addr_o, 32'h30);
    chk("drain_flush_valid", 32'(ifid_valid_o), 32'h0);
    chk("drain_flush_instr", ifid_instr_o, NOP);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    chk("drain_busy", 32'(last_busy), 32'h1);
    chk("drain_addr2", imem_addr_o, 32'h30);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("post_drain_addr", imem_addr_o, 32'h100);
    chk("post_drain_valid", 32'(ifid_valid_o), 32'h0);

    // Branch and stall together with the skid full.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("skidfull_req", 32'(imem_req_o), 32'h0);
    cycle(1'b1, 1'b1, 32'h200, 1'b1);
    chk("brstall_addr", imem_addr_o, 32'h200);
    chk("brstall_req", 32'(imem_req_o), 32'h1);
    chk("brstall_valid", 32'(ifid_valid_o), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("brstall_next_pc4", ifid_pc4_o, 32'h204);
    chk("brstall_next_instr", ifid_instr_o, 32'h200 + 32'd1000);

    // PC wrap-around.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_discard_valid", 32'(ifid_valid_o), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc4", ifid_pc4_o, 32'h0);
    chk("wrap_instr", ifid_instr_o, 32'h0000_03E4);
    chk("wrap_next_addr", imem_addr_o, 32'h0);

    // Asynchronous reset in the middle of a drain.
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    chk("pre_clr_busy", 32'(fetch_busy_o), 32'h1);
    #2;
    CLR = 1'b0;
    imem_ready_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
    #1;
    chk_reset_outputs("async_clr");
    m_reset();
    @(negedge CLK);
    CLR = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), tgt,
            ($urandom_range(0, 2) != 0));
    end
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
